// File: rtl/mips_defs_pkg.sv
// Shared MIPS encodings for the multi-cycle control unit.
// Opcodes, functs, ALU codes, mux selects, FSM states.
package mips_defs_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2a;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  localparam logic [1:0] PC_ALU = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;
  localparam logic [1:0] PC_RS  = 2'd3;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MDR = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;

  localparam logic [1:0] SRCB_RT   = 2'd0;
  localparam logic [1:0] SRCB_4    = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;
  localparam logic [1:0] SRCB_IMM2 = 2'd3;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_ADDR   = 4'd2,
    S_MRD    = 4'd3,
    S_LWB    = 4'd4,
    S_MWR    = 4'd5,
    S_IEXE   = 4'd6,
    S_IWB    = 4'd7,
    S_REXE   = 4'd8,
    S_RWB    = 4'd9,
    S_BR     = 4'd10,
    S_JMP    = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13,
    S_TRAP   = 4'd14
  } state_t;

  typedef enum logic [1:0] {
    ALU_CLS_ADD,
    ALU_CLS_SUB,
    ALU_CLS_IMM,
    ALU_CLS_RTYPE
  } alu_cls_t;

endpackage

// File: rtl/mc_alu_decode.sv
// ALU control decode from state class, opcode and funct.
// In: i_cls, i_op, i_funct. Out: o_alu_ctrl.
module mc_alu_decode
  import mips_defs_pkg::*;
#(
  parameter int OP_W  = 6,
  parameter int FN_W  = 6,
  parameter int ALU_W = 3
)(
  input  alu_cls_t          i_cls,
  input  logic [OP_W-1:0]   i_op,
  input  logic [FN_W-1:0]   i_funct,
  output logic [ALU_W-1:0]  o_alu_ctrl
);

  always_comb begin
    o_alu_ctrl = ALU_W'(ALU_ADD);
    unique case (i_cls)
      ALU_CLS_ADD: o_alu_ctrl = ALU_W'(ALU_ADD);
      ALU_CLS_SUB: o_alu_ctrl = ALU_W'(ALU_SUB);
      ALU_CLS_IMM: begin
        if (i_op == OP_W'(OP_XORI))
          o_alu_ctrl = ALU_W'(ALU_XOR);
      end
      ALU_CLS_RTYPE: begin
        if (i_funct == FN_W'(FN_SUB))
          o_alu_ctrl = ALU_W'(ALU_SUB);
        else if (i_funct == FN_W'(FN_SLT))
          o_alu_ctrl = ALU_W'(ALU_SLT);
      end
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM driving all datapath strobes.
// Optional MC_CONTROL_ILLEGAL_TRAP_EN adds TRAP + illegal_instr.
module mc_control_unit
  import mips_defs_pkg::*;
#(
  parameter int OP_W  = 6,
  parameter int FN_W  = 6,
  parameter int ALU_W = 3
)(
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  op,
  input  logic [FN_W-1:0]  funct,
  input  logic             mem_ready,
  input  logic             alu_zero,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [ALU_W-1:0] alu_ctrl,
  output logic [3:0]       state_o
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
  ,
  output logic             illegal_instr
`endif
);

  state_t            r_state;
  state_t            w_next;
  logic [OP_W-1:0]   r_op;
  logic [FN_W-1:0]   r_funct;
  alu_cls_t          w_cls;
  logic [ALU_W-1:0]  w_alu_ctrl;

  logic w_mem, w_imm, w_r, w_jr;
  logic w_br, w_j, w_jal, w_op0;

  assign w_op0 = op == OP_W'(OP_RTYPE);
  assign w_mem = op == OP_W'(OP_LW) ||
                 op == OP_W'(OP_SW);
  assign w_imm = op == OP_W'(OP_ADDI) ||
                 op == OP_W'(OP_XORI);
  assign w_r   = w_op0 &&
                 (funct == FN_W'(FN_ADD) ||
                  funct == FN_W'(FN_SUB) ||
                  funct == FN_W'(FN_SLT));
  assign w_jr  = w_op0 && funct == FN_W'(FN_JR);
  assign w_br  = op == OP_W'(OP_BEQ) ||
                 op == OP_W'(OP_BNE);
  assign w_j   = op == OP_W'(OP_J);
  assign w_jal = op == OP_W'(OP_JAL);

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:
        w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          w_mem:   w_next = S_ADDR;
          w_imm:   w_next = S_IEXE;
          w_r:     w_next = S_REXE;
          w_jr:    w_next = S_JR;
          w_br:    w_next = S_BR;
          w_j:     w_next = S_JMP;
          w_jal:   w_next = S_JAL;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
          default: w_next = S_TRAP;
`else
          default: w_next = S_FETCH;
`endif
        endcase
      end
      S_ADDR:
        w_next = (r_op == OP_W'(OP_LW)) ?
                 S_MRD : S_MWR;
      S_MRD:
        w_next = mem_ready ? S_LWB : S_MRD;
      S_MWR:
        w_next = mem_ready ? S_FETCH : S_MWR;
      S_IEXE: w_next = S_IWB;
      S_REXE: w_next = S_RWB;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
      S_TRAP: w_next = S_TRAP;
`endif
      default: w_next = S_FETCH;
    endcase
  end

  // op/funct are captured on the DECODE edge; the IR
  // may be reloaded later, so EXEC states use the copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_op    <= '0;
      r_funct <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_op    <= op;
        r_funct <= funct;
      end
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    pc_src     = PC_ALU;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = RD_RT;
    mem_to_reg = M2R_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    w_cls      = ALU_CLS_ADD;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_4;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: alu_src_b = SRCB_IMM2;
        S_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MRD: begin
          i_or_d   = 1'b1;
          mem_read = 1'b1;
        end
        S_LWB: begin
          reg_write  = 1'b1;
          mem_to_reg = M2R_MDR;
        end
        S_MWR: begin
          i_or_d    = 1'b1;
          mem_write = 1'b1;
        end
        S_IEXE: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          w_cls     = ALU_CLS_IMM;
        end
        S_IWB: reg_write = 1'b1;
        S_REXE: begin
          alu_src_a = 1'b1;
          w_cls     = ALU_CLS_RTYPE;
        end
        S_RWB: begin
          reg_write = 1'b1;
          reg_dst   = RD_RD;
        end
        S_BR: begin
          alu_src_a = 1'b1;
          w_cls     = ALU_CLS_SUB;
          pc_src    = PC_BR;
          pc_write  = (r_op == OP_W'(OP_BNE)) ?
                      !alu_zero : alu_zero;
        end
        S_JMP: begin
          pc_write = 1'b1;
          pc_src   = PC_JMP;
        end
        S_JAL: begin
          reg_write  = 1'b1;
          reg_dst    = RD_RA;
          mem_to_reg = M2R_PC;
          pc_write   = 1'b1;
          pc_src     = PC_JMP;
        end
        S_JR: begin
          pc_write = 1'b1;
          pc_src   = PC_RS;
        end
        default: ;
      endcase
    end
  end

  mc_alu_decode #(
    .OP_W  (OP_W),
    .FN_W  (FN_W),
    .ALU_W (ALU_W)
  ) u_alu_dec (
    .i_cls      (w_cls),
    .i_op       (r_op),
    .i_funct    (r_funct),
    .o_alu_ctrl (w_alu_ctrl)
  );

  assign alu_ctrl = reset ? '0 : w_alu_ctrl;
  assign state_o  = reset ? S_FETCH : r_state;

`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
  assign illegal_instr = !reset &&
                         r_state == S_TRAP;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit.
// Hand-computed expectations per instruction flow.
module tb_mc_control_unit;

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_ADDR   = 4'd2;
  localparam logic [3:0] ST_MRD    = 4'd3;
  localparam logic [3:0] ST_LWB    = 4'd4;
  localparam logic [3:0] ST_MWR    = 4'd5;
  localparam logic [3:0] ST_IEXE   = 4'd6;
  localparam logic [3:0] ST_REXE   = 4'd8;
  localparam logic [3:0] ST_RWB    = 4'd9;
  localparam logic [3:0] ST_BR     = 4'd10;
  localparam logic [3:0] ST_JAL    = 4'd12;
  localparam logic [3:0] ST_TRAP   = 4'd14;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       mem_ready;
  logic       alu_zero;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctrl;
  logic [3:0] state_o;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
  logic       illegal_instr;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mc_control_unit dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .mem_ready  (mem_ready),
    .alu_zero   (alu_zero),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .ir_write   (ir_write),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_ctrl   (alu_ctrl),
    .state_o    (state_o)
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    ,
    .illegal_instr (illegal_instr)
`endif
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic to_state(input string tag,
                          input logic [3:0] st);
    int k = 0;
    while (state_o !== st && k < 12) begin
      cyc();
      k++;
    end
    check(tag, state_o, st);
  endtask

  // Cycles from FETCH until FETCH is re-entered.
  task automatic lat(input string tag,
                     input logic [5:0] o,
                     input logic [5:0] f,
                     input int exp);
    int n = 0;
    op    = o;
    funct = f;
    do begin
      cyc();
      n++;
    end while (state_o !== ST_FETCH && n < 20);
    check(tag, n, exp);
  endtask

  initial begin
    int mw;
    int rw;
    reset     = 1'b1;
    op        = 6'h23;
    funct     = 6'h00;
    mem_ready = 1'b1;
    alu_zero  = 1'b0;
    cyc();
    cyc();
    check("rst_state", state_o, ST_FETCH);
    check("rst_mrd", mem_read, 0);
    check("rst_pcw", pc_write, 0);
    check("rst_irw", ir_write, 0);

    // LW walk
    reset = 1'b0;
    #1;
    check("f_irw", ir_write, 1);
    check("f_pcw", pc_write, 1);
    check("f_srcb", alu_src_b, 1);
    cyc();
    check("lw_dec", state_o, ST_DECODE);
    check("dec_srcb", alu_src_b, 3);
    cyc();
    check("lw_addr", state_o, ST_ADDR);
    check("addr_srcb", alu_src_b, 2);
    cyc();
    check("lw_mrd", state_o, ST_MRD);
    check("mrd_iord", i_or_d, 1);
    check("mrd_rd", mem_read, 1);
    cyc();
    check("lw_lwb", state_o, ST_LWB);
    check("lwb_rw", reg_write, 1);
    check("lwb_dst", reg_dst, 0);
    check("lwb_m2r", mem_to_reg, 1);
    cyc();
    check("lw_end", state_o, ST_FETCH);

    // SW with 3 stall cycles
    op = 6'h2b;
    cyc();
    cyc();
    cyc();
    check("sw_mwr", state_o, ST_MWR);
    mw = 0;
    rw = 0;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (mem_write) mw++;
      if (reg_write) rw++;
      cyc();
    end
    check("sw_hold", state_o, ST_MWR);
    mem_ready = 1'b1;
    #1;
    if (mem_write) mw++;
    if (reg_write) rw++;
    cyc();
    check("sw_wcnt", mw, 4);
    check("sw_rw", rw, 0);
    check("sw_end", state_o, ST_FETCH);
    check("sw_wdone", mem_write, 0);

    // BEQ taken
    op = 6'h04;
    alu_zero = 1'b1;
    to_state("beq_br", ST_BR);
    check("beq_pcw", pc_write, 1);
    check("beq_src", pc_src, 1);
    check("beq_alu", alu_ctrl, 1);
    cyc();

    // BNE with zero=1 (not taken), then zero=0
    op = 6'h05;
    to_state("bne_br", ST_BR);
    check("bne_pcw1", pc_write, 0);
    alu_zero = 1'b0;
    #1;
    check("bne_pcw0", pc_write, 1);
    cyc();

    // SLT
    op = 6'h00;
    funct = 6'h2a;
    to_state("slt_rexe", ST_REXE);
    check("slt_alu", alu_ctrl, 3);
    check("slt_srca", alu_src_a, 1);
    cyc();
    check("slt_rwb", state_o, ST_RWB);
    check("slt_dst", reg_dst, 1);
    check("slt_rw", reg_write, 1);
    cyc();

    // XORI
    op = 6'h0e;
    to_state("xori_iexe", ST_IEXE);
    check("xori_alu", alu_ctrl, 2);
    check("xori_srcb", alu_src_b, 2);
    cyc();
    cyc();

    // JAL
    op = 6'h03;
    to_state("jal_st", ST_JAL);
    check("jal_dst", reg_dst, 2);
    check("jal_m2r", mem_to_reg, 2);
    check("jal_pcw", pc_write, 1);
    check("jal_src", pc_src, 2);
    check("jal_rw", reg_write, 1);
    cyc();

    // JR state check and latencies
    op = 6'h00;
    funct = 6'h08;
    cyc();
    cyc();
    check("jr_src", pc_src, 3);
    check("jr_pcw", pc_write, 1);
    cyc();
    check("jr_end", state_o, ST_FETCH);

    lat("lat_lw", 6'h23, 6'h00, 5);
    lat("lat_sw", 6'h2b, 6'h00, 4);
    lat("lat_add", 6'h00, 6'h20, 4);
    lat("lat_sub", 6'h00, 6'h22, 4);
    lat("lat_addi", 6'h08, 6'h00, 4);
    lat("lat_j", 6'h02, 6'h00, 3);
    lat("lat_beq", 6'h04, 6'h00, 3);
    lat("lat_jr", 6'h00, 6'h08, 3);
`ifndef MC_CONTROL_ILLEGAL_TRAP_EN
    lat("lat_nop", 6'h3f, 6'h00, 2);
    lat("lat_badfn", 6'h00, 6'h01, 2);
`endif

    // Reset during MRD
    op = 6'h23;
    to_state("rm_mrd", ST_MRD);
    mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("rm_rd", mem_read, 0);
    check("rm_iord", i_or_d, 0);
    check("rm_state", state_o, ST_FETCH);
    cyc();
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("rm_fetch", state_o, ST_FETCH);
    check("rm_frd", mem_read, 1);

`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    op = 6'h3f;
    cyc();
    cyc();
    check("trap_st", state_o, ST_TRAP);
    check("trap_ill", illegal_instr, 1);
    check("trap_rd", mem_read, 0);
    repeat (3) cyc();
    check("trap_hold", state_o, ST_TRAP);
    reset = 1'b1;
    #1;
    check("trap_rill", illegal_instr, 0);
    cyc();
    reset = 1'b0;
    #1;
    check("trap_exit", state_o, ST_FETCH);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule
